// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: drives one registered PE through a dot product of cfg_len terms,
// accumulates the products and returns the sum through a valid/ready handshake.
`default_nettype none

module pe_dot_sequencer #(
  parameter int DATA_W = 8,
  parameter int PROD_W = 20,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_rd_addr,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [PROD_W-1:0] pe_product,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] ifm_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic              drain_cnt;
  logic [1:0]        vld;
  logic [ACC_W-1:0]  acc;
  logic              accept;
  logic              fetch_last;

  assign accept     = (state == IDLE) && start;
  assign fetch_last = (cnt == len_q - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == '0) ? OUT : FETCH;
      FETCH:   if (fetch_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = OUT;
      OUT:     if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign ifm_rd_en    = (state == FETCH);
  assign wgt_rd_en    = ifm_rd_en;
  assign ifm_rd_addr  = ifm_rd_en ? ifm_base_q + ADDR_W'(cnt) : '0;
  assign wgt_rd_addr  = ifm_rd_en ? wgt_base_q + ADDR_W'(cnt) : '0;
  assign busy         = (state != IDLE);
  assign result_valid = (state == OUT);
  assign result       = result_valid ? acc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      ifm_base_q <= '0;
      wgt_base_q <= '0;
      cnt        <= '0;
      drain_cnt  <= 1'b0;
      vld        <= '0;
      acc        <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (accept) begin
        len_q      <= cfg_len;
        ifm_base_q <= cfg_ifm_base;
        wgt_base_q <= cfg_wgt_base;
        cnt        <= '0;
        vld        <= '0;
        acc        <= '0;
      end else begin
        if (state == FETCH) cnt <= cnt + LEN_W'(1);
        // Stage 2 marks the cycle the PE output belongs to a fetched term.
        vld <= {vld[0], ifm_rd_en};
        if (vld[1]) acc <= acc + ACC_W'(pe_product);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_dot_sequencer.sv
// Self-checking bench for pe_dot_sequencer: SRAM + PE model, scoreboard of expected sums.
`default_nettype none

module tb_pe_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  cfg_len;
  logic [9:0]  cfg_ifm_base;
  logic [9:0]  cfg_wgt_base;
  logic        ifm_rd_en, wgt_rd_en;
  logic [9:0]  ifm_rd_addr, wgt_rd_addr;
  logic [19:0] pe_product;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  logic        b_start;
  logic [9:0]  b_len, b_ifm_base, b_wgt_base;
  logic        b_ifm_rd_en, b_wgt_rd_en;
  logic [9:0]  b_ifm_rd_addr, b_wgt_rd_addr;
  logic [15:0] b_pe_product;
  logic        b_busy;
  logic [15:0] b_result;
  logic        b_result_valid;
  logic        b_result_ready;

  logic [7:0]  ifm_mem [0:1023];
  logic [7:0]  wgt_mem [0:1023];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          t0       = 0;
  longint      sb[$];

  always #5 clk = ~clk;

  pe_dot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .cfg_ifm_base(cfg_ifm_base), .cfg_wgt_base(cfg_wgt_base),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
    .pe_product(pe_product), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  pe_dot_sequencer #(.PROD_W(16), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .cfg_len(b_len),
    .cfg_ifm_base(b_ifm_base), .cfg_wgt_base(b_wgt_base),
    .ifm_rd_en(b_ifm_rd_en), .ifm_rd_addr(b_ifm_rd_addr),
    .wgt_rd_en(b_wgt_rd_en), .wgt_rd_addr(b_wgt_rd_addr),
    .pe_product(b_pe_product), .busy(b_busy), .result(b_result),
    .result_valid(b_result_valid), .result_ready(b_result_ready)
  );

  // SRAM read ports return garbage when not strobed; the PE multiplies every cycle.
  logic [7:0] a_ifm_q, a_wgt_q, b_ifm_q, b_wgt_q;
  always @(posedge clk) begin
    a_ifm_q      <= ifm_rd_en   ? ifm_mem[ifm_rd_addr]   : 8'($urandom);
    a_wgt_q      <= wgt_rd_en   ? wgt_mem[wgt_rd_addr]   : 8'($urandom);
    b_ifm_q      <= b_ifm_rd_en ? ifm_mem[b_ifm_rd_addr] : 8'($urandom);
    b_wgt_q      <= b_wgt_rd_en ? wgt_mem[b_wgt_rd_addr] : 8'($urandom);
    pe_product   <= 20'(a_ifm_q) * 20'(a_wgt_q);
    b_pe_product <= 16'(b_ifm_q) * 16'(b_wgt_q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input int len, input int ib, input int wb);
    longint s = 0;
    for (int i = 0; i < len; i++)
      s += longint'(ifm_mem[10'((ib + i) % 1024)]) * longint'(wgt_mem[10'((wb + i) % 1024)]);
    sb.push_back(s % 64'h1_0000_0000);
    start        = 1'b1;
    cfg_len      = 10'(len);
    cfg_ifm_base = 10'(ib);
    cfg_wgt_base = 10'(wb);
    t0 = cyc;
    tick();
    start        = 1'b0;
    cfg_len      = 10'($urandom);
    cfg_ifm_base = 10'($urandom);
    cfg_wgt_base = 10'($urandom);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(result_valid), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
  endtask

  task automatic check_result(input string tag);
    longint e = -1;
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, "_result"}, 64'(result), 64'(e));
  endtask

  task automatic check_fetch(input string tag, input int len, input int ib, input int wb);
    for (int i = 0; i < len; i++) begin
      chk({tag, "_rd_en"}, 64'({ifm_rd_en, wgt_rd_en}), 64'd3);
      chk({tag, "_ifm_addr"}, 64'(ifm_rd_addr), 64'((ib + i) % 1024));
      chk({tag, "_wgt_addr"}, 64'(wgt_rd_addr), 64'((wb + i) % 1024));
      tick();
    end
    chk({tag, "_drain_rd_en"}, 64'({ifm_rd_en, wgt_rd_en}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_ifm_base = '0; cfg_wgt_base = '0;
    result_ready = 1'b1;
    b_start = 1'b0; b_len = '0; b_ifm_base = '0; b_wgt_base = '0; b_result_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ifm_mem[i] = 8'($urandom);
      wgt_mem[i] = 8'($urandom);
    end
    tick(); tick(); tick();
    chk("reset_outputs", 64'({busy, ifm_rd_en, wgt_rd_en, result_valid}), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic: {1,2,3,4}.{5,6,7,8} = 70, latency 7
    for (int i = 0; i < 4; i++) begin
      ifm_mem[10 + i] = 8'(i + 1);
      wgt_mem[40 + i] = 8'(i + 5);
    end
    launch(4, 10, 40);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_expect", 64'(sb[0]), 64'd70);
    check_fetch("basic", 4, 10, 40);
    wait_valid("basic", 7);
    check_result("basic");
    tick();
    chk("basic_idle", 64'(busy), 64'd0);

    // Max operands, stale PE outputs must not be summed
    for (int i = 0; i < 3; i++) begin
      ifm_mem[200 + i] = 8'd255;
      wgt_mem[200 + i] = 8'd255;
    end
    launch(3, 200, 200);
    wait_valid("max", 6);
    chk("max_value", 64'(result), 64'd195075);
    check_result("max");
    tick();

    // Address wrap through 1023 -> 0
    ifm_mem[1022] = 8'd9; ifm_mem[1023] = 8'd10; ifm_mem[0] = 8'd11; ifm_mem[1] = 8'd12;
    for (int i = 0; i < 4; i++) wgt_mem[500 + i] = 8'(i + 2);
    launch(4, 1022, 500);
    check_fetch("wrap", 4, 1022, 500);
    wait_valid("wrap", 7);
    check_result("wrap");
    tick();

    // Zero length
    launch(0, 5, 5);
    chk("zero_rd_en", 64'({ifm_rd_en, wgt_rd_en}), 64'd0);
    wait_valid("zero", 1);
    chk("zero_value", 64'(result), 64'd0);
    check_result("zero");
    tick();
    chk("zero_idle", 64'(busy), 64'd0);

    // Back-pressure with ignored start pulses
    result_ready = 1'b0;
    ifm_mem[300] = 8'd7;  ifm_mem[301] = 8'd9;
    wgt_mem[300] = 8'd11; wgt_mem[301] = 8'd13;
    launch(2, 300, 300);
    wait_valid("bp", 5);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1;
        cfg_len = 10'd0;
      end
      tick();
      start = 1'b0;
      chk("bp_hold_valid", 64'(result_valid), 64'd1);
      chk("bp_hold_result", 64'(result), 64'(sb[0]));
    end
    chk("bp_expect", 64'(sb[0]), 64'd194);
    result_ready = 1'b1;
    start = 1'b1;
    check_result("bp");
    tick();
    start = 1'b0;
    chk("bp_after_hs", 64'({busy, result_valid}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      ifm_mem[400 + i] = 8'd1;
      wgt_mem[400 + i] = 8'd2;
    end
    launch(3, 400, 400);
    wait_valid("bp_next", 6);
    chk("bp_next_value", 64'(result), 64'd6);
    check_result("bp_next");
    tick();

    // Mid-operation asynchronous reset
    launch(8, 600, 600);
    tick();
    chk("mid_fetch", 64'(ifm_rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({busy, ifm_rd_en, wgt_rd_en, result_valid}), 64'd0);
    chk("mid_rst_addr", 64'({ifm_rd_addr, wgt_rd_addr}), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_post_idle", 64'(busy), 64'd0);
    ifm_mem[700] = 8'd3; ifm_mem[701] = 8'd4;
    wgt_mem[700] = 8'd5; wgt_mem[701] = 8'd6;
    launch(2, 700, 700);
    wait_valid("mid_after", 5);
    chk("mid_after_value", 64'(result), 64'd39);
    check_result("mid_after");
    tick();

    // 16-bit accumulator wraps: 2 * 65025 mod 65536 = 64514
    ifm_mem[800] = 8'd255; ifm_mem[801] = 8'd255;
    wgt_mem[800] = 8'd255; wgt_mem[801] = 8'd255;
    b_start = 1'b1; b_len = 10'd2; b_ifm_base = 10'd800; b_wgt_base = 10'd800;
    tick();
    b_start = 1'b0;
    for (int n = 0; n < 40 && !b_result_valid; n++) tick();
    chk("acc16_valid", 64'(b_result_valid), 64'd1);
    chk("acc16_result", 64'(b_result), 64'd64514);
    tick();
    chk("acc16_idle", 64'(b_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_dot_sequencer.md
# pe_dot_sequencer

Sequencer that drives one PE (registered unsigned multiplier, one-cycle latency, no enable) through a dot product of configurable length. It issues operand reads to the IFM and weight SRAMs, tracks which PE outputs are valid, accumulates them, and returns the sum through a valid/ready handshake. It sits between the layer controller, which issues `start` and the config, and a single PE, whose operands come straight from the SRAM read ports.

## Interface
- `DATA_W`, default 8: operand width fed to the PE.
- `PROD_W`, default 20: PE product width.
- `ACC_W`, default 32: accumulator and result width.
- `ADDR_W`, default 10: SRAM address width.
- `LEN_W`, default 10: length field width.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `cfg_len`  in  LEN_W  number of MAC terms; sampled with `start`.
- `cfg_ifm_base`  in  ADDR_W  first IFM address; sampled with `start`.
- `cfg_wgt_base`  in  ADDR_W  first weight address; sampled with `start`.
- `ifm_rd_en`  out  1  IFM SRAM read strobe; data is valid one cycle later.
- `ifm_rd_addr`  out  ADDR_W  IFM read address.
- `wgt_rd_en`  out  1  weight SRAM read strobe; always equal to `ifm_rd_en`.
- `wgt_rd_addr`  out  ADDR_W  weight read address.
- `pe_product`  in  PROD_W  PE output.
- `busy`  out  1  high in every state except IDLE.
- `result`  out  ACC_W  dot-product sum.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  consumer accepts `result`.

## Operation
- The FSM has four states: IDLE, FETCH, DRAIN, OUT.
- **IDLE → FETCH:** on `start` with `cfg_len` ≠ 0.
  - Latch the config.
  - Clear the accumulator and the valid pipeline.
  - Set the term counter to 0.
- **IDLE → OUT:** on `start` with `cfg_len` = 0. `result` = 0.
- **FETCH:**
  - Assert `ifm_rd_en` and `wgt_rd_en` every cycle.
  - Addresses are base + counter, modulo 2^ADDR_W, so they wrap from all-ones to 0.
  - Move to DRAIN after the cycle with counter = len−1.
- **DRAIN:** hold for exactly 2 cycles with the read strobes low, then move to OUT.
- **OUT:**
  - `result_valid` = 1.
  - `result` is held stable until `result_ready` = 1.
  - On the handshake, return to IDLE.
- **Valid tracking:** a 2-stage shift register delays `ifm_rd_en`, covering the SRAM cycle plus the PE cycle.
  - When stage 2 is high, the accumulator adds `pe_product` zero-extended to ACC_W.
  - Otherwise the accumulator holds, so the free-running PE output is never summed outside a valid slot.
- **Arithmetic:** unsigned; the accumulator wraps modulo 2^ACC_W with no saturation.
- **Ignored inputs:** `start` outside IDLE is ignored, including in the OUT handshake cycle. Config inputs are ignored outside the `start` sample.
- **Reset, at any time including mid-operation:**
  - State returns to IDLE.
  - The accumulator, counter, valid pipeline and latched config are cleared.
  - All outputs go to 0: `busy`, `ifm_rd_en`, `wgt_rd_en`, both addresses, `result`, `result_valid`.
  - No partial result is ever presented.

## Timing
- `start` is sampled at edge E0, which ends cycle T.
- FETCH occupies cycles T+1 .. T+len.
  - Read strobes are high in those cycles.
  - Read address in cycle T+1+i is base+i.
- PE product for term i is valid in cycle T+3+i. It is accumulated at the end of that cycle.
- DRAIN occupies cycles T+len+1 and T+len+2.
- `result_valid` rises in cycle T+len+3, so latency from `start` to `result_valid` is len+3 cycles.
- For len = 0, `result_valid` rises in cycle T+1.
- `busy` rises in cycle T+1 and falls in the cycle after the handshake.
- With `result_ready` tied high, `start` is next accepted in cycle T+len+4, giving throughput of one dot product per len+4 cycles.
- Back-pressure: OUT persists indefinitely while `result_ready` = 0. `result` must not change.

## Test plan
- **Basic:** len=4, IFM = {1,2,3,4}, W = {5,6,7,8}, `result_ready` tied 1.
  - Expect `result` = 70 with `result_valid` rising exactly 7 cycles after `start`.
  - Expect addresses base..base+3 on consecutive cycles.
- **Max operands:** len=3, all operands 255.
  - Expect `result` = 195075.
  - Confirm that the stale PE outputs present before the first valid slot and during DRAIN are not summed.
- **Wrap and zero-length:**
  - base = 2^ADDR_W−2, len=4: expect addresses 1022, 1023, 0, 1 (ADDR_W=10).
  - len=0: expect `result` = 0 with `result_valid` one cycle after `start` and no read strobes.
- **Back-pressure:** hold `result_ready` = 0 for 5 cycles in OUT.
  - `result` and `result_valid` stay stable.
  - A `start` pulse during OUT is ignored.
  - After the handshake, a new `start` runs normally and its result is independent of the previous sum.
- **Mid-op reset:** assert `rst_n` = 0 in the 2nd FETCH cycle of a len=8 run.
  - All outputs are 0 immediately, since reset is asynchronous.
  - After release, a len=2 run with {3,4}·{5,6} gives 39.
- **Accumulator wrap:** ACC_W=16, len=2, operands 255·255 twice.
  - Expect `result` = 130050 mod 65536 = 64514.
